// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between writeback (port A, always wins) and
// the multiply/divide unit (port B, buffered in a one-entry holding register).
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        pend_valid,
  output logic [4:0]  pend_reg,
  output logic        stall_req,
  output logic        b_killed
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic {StEmpty, StHeld} state_e;

  state_e      state_q, state_d;
  logic [4:0]  held_reg_q, held_reg_d;
  logic [31:0] held_data_q, held_data_d;
  logic [3:0]  age_q, age_d;
  logic        we_q, we_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        stall_q, stall_d;
  logic        killed_q, killed_d;
  logic        a_write;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StEmpty;
      held_reg_q  <= '0;
      held_data_q <= '0;
      age_q       <= '0;
      we_q        <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      stall_q     <= 1'b0;
      killed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      held_reg_q  <= held_reg_d;
      held_data_q <= held_data_d;
      age_q       <= age_d;
      we_q        <= we_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      stall_q     <= stall_d;
      killed_q    <= killed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    held_reg_d  = held_reg_q;
    held_data_d = held_data_q;
    age_d       = age_q;
    we_d        = 1'b0;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    killed_d    = 1'b0;
    // Writes to $r0 are dropped and count as an idle A cycle.
    a_write     = a_valid && (a_reg != 5'd0);

    if (a_write) begin
      we_d    = 1'b1;
      wreg_d  = a_reg;
      wdata_d = a_data;
    end

    unique case (state_q)
      StEmpty: begin
        if (b_valid && (b_reg != 5'd0)) begin
          state_d     = StHeld;
          held_reg_d  = b_reg;
          held_data_d = b_data;
          age_d       = '0;
        end
      end
      StHeld: begin
        if (a_write && (a_reg == held_reg_q)) begin
          // A carries the newer value for this register; the held result is stale.
          killed_d = 1'b1;
          state_d  = StEmpty;
        end else if (a_write) begin
          if (age_q != 4'hF) age_d = age_q + 4'd1;
        end else begin
          we_d    = 1'b1;
          wreg_d  = held_reg_q;
          wdata_d = held_data_q;
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Built from current state so it drops one cycle after the entry leaves.
    stall_d = (state_q == StHeld) && (age_q >= Limit);
  end

  assign b_ready          = (state_q == StEmpty);
  assign pend_valid       = (state_q == StHeld);
  assign pend_reg         = (state_q == StHeld) ? held_reg_q : 5'd0;
  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign stall_req        = stall_q;
  assign b_killed         = killed_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the pipeline writeback stage (port A) and the multiply/divide unit (port B). Port A is never stalled and always wins the port. Port B results wait in a one-entry holding buffer and drain on the first idle cycle. The block drives the register file's `ctrl_writeEnable` / `ctrl_writeReg` / `data_writeReg` inputs from registered outputs, suppresses all writes to `$r0`, and exposes the pending destination to hazard logic.

## Interface
- `STARVE_LIMIT`, 4: number of cycles a held B entry waits before `stall_req` asserts; legal range 1..15.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserted when 0, released synchronously to `clock` by the top level.
- `a_valid`  in  1  writeback stage has a result this cycle.
- `a_reg`  in  5  port A destination register.
- `a_data`  in  32  port A write data.
- `b_valid`  in  1  multdiv result offered.
- `b_reg`  in  5  port B destination register.
- `b_data`  in  32  port B write data.
- `b_ready`  out  1  holding buffer empty; B transfer occurs on `b_valid & b_ready`.
- `ctrl_writeEnable`  out  1  register file write enable (registered).
- `ctrl_writeReg`  out  5  register file write address (registered).
- `data_writeReg`  out  32  register file write data (registered).
- `pend_valid`  out  1  holding buffer occupied.
- `pend_reg`  out  5  destination of held entry; 0 when `pend_valid`=0.
- `stall_req`  out  1  request to the pipeline to idle port A next cycle.
- `b_killed`  out  1  one-cycle pulse: held entry discarded due to a newer A write.

## Operation
- Buffer states:
  - EMPTY: `b_ready`=1.
  - HELD: `b_ready`=0, `pend_valid`=1.
- Write-port selection each cycle, in priority order:
  1. `a_valid` & `a_reg`≠0: register A's register and data; write enable = 1.
  2. Else if HELD: register the buffer's register and data; write enable = 1; next state EMPTY.
  3. Otherwise: write enable = 0; address and data registers hold their previous values.
- `$r0` rule:
  - An A write with `a_reg`=0 produces no write. It counts as an idle A cycle, so a HELD entry drains in that cycle.
  - A B transfer with `b_reg`=0 completes the handshake but does not load the buffer; state stays EMPTY.
- EMPTY + B transfer with `b_reg`≠0: load `b_reg`/`b_data`; next state HELD; age counter cleared to 0.
- HELD + A write with `a_reg` = held register (nonzero):
  - The held entry is discarded (A is the newer value); next state EMPTY.
  - `b_killed` pulses in the following cycle.
  - A is written normally.
- Age counter:
  - 4-bit, increments each cycle the entry remains HELD and is not drained or killed; saturates at 15.
  - `stall_req` is registered: 1 when HELD and age ≥ `STARVE_LIMIT`. It deasserts the cycle after the entry leaves HELD.
  - The arbiter does not enforce the stall. If `a_valid` stays high, A keeps winning.
- A B transfer cannot occur in the cycle the buffer drains, because `b_ready` is a pure function of state.

## Timing
- Reset values: all outputs 0, except `b_ready`=1. Buffer EMPTY, age 0.
- Reset assertion mid-operation: the held entry is lost; outputs go to reset values immediately, without waiting for a clock edge.
- Latency:
  - A presented in cycle N is on the write port in cycle N+1.
  - B accepted in cycle N is HELD in N+1; if A is idle in N+1, it is on the write port in N+2.
- B throughput: at most one result per 2 cycles.
- `pend_valid` / `pend_reg` reflect state registers only, with no combinational path from inputs.
- `b_ready` likewise has no combinational path from inputs.

## Test plan
- A only: `a_valid`=1, `a_reg`=5, `a_data`=0xDEADBEEF in cycle 1 -> cycle 2: `ctrl_writeEnable`=1, `ctrl_writeReg`=5, `data_writeReg`=0xDEADBEEF. With `a_reg`=0 instead -> `ctrl_writeEnable`=0.
- B with idle A: `b_valid`=1, `b_reg`=9, `b_data`=0x12 in cycle 1 -> cycle 2: `pend_valid`=1, `pend_reg`=9, `b_ready`=0. Cycle 3: write of reg 9 = 0x12. Cycle 3: `b_ready`=1.
- Collision and starvation: B (reg 7) accepted, then `a_valid`=1 to other nonzero registers for 6 cycles with `STARVE_LIMIT`=4.
  - `stall_req` rises after age reaches 4.
  - Reg 7 is written the cycle after A goes idle.
  - `stall_req` falls the following cycle.
- Kill: B (reg 3, 0xAA) held, then A writes reg 3 = 0xBB -> write port shows 0xBB. `b_killed` pulses once. `pend_valid`=0. No later write of 0xAA.
- B to `$r0`: `b_valid`=1, `b_reg`=0 -> handshake completes. `pend_valid` stays 0. No write occurs.
- Async reset mid-hold: drop `reset` low between clock edges while HELD -> `pend_valid`, `stall_req` and `ctrl_writeEnable` go to 0 and `b_ready` goes to 1 immediately. No write occurs after release.
